// File: rtl/rgb_pwm_decoder.sv
// rgb_pwm_decoder: measures the high-time fraction of three asynchronous PWM
// inputs over a free-running window of 2^WINDOW_LOG2 clk cycles and reports
// the result as an RGB565 pixel with a one-cycle valid strobe.
// Optional build macro PWM_DEGLITCH_EN adds a per-channel two-sample glitch
// filter after the synchronizers (one extra cycle of latency).
module rgb_pwm_decoder #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rPwm,
  input  logic        gPwm,
  input  logic        bPwm,
  output logic [15:0] pixel,
  output logic        pixelValid,
  output logic        busy
);

  localparam int SHR = WINDOW_LOG2 - 5;
  localparam int SHG = WINDOW_LOG2 - 6;

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  state_t state_q, state_d;

  // Channel order in all 3-bit vectors: [2]=red, [1]=green, [0]=blue.
  logic [2:0] pwm_raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] sample;

  logic [WINDOW_LOG2-1:0] win_q;
  logic                   last_win;
  logic                   count_en;
  logic                   load_pixel;
  logic [WINDOW_LOG2:0]   high_cnt [3];

  logic [15:0] pixel_q;
  logic        valid_q;

  assign pwm_raw = {rPwm, gPwm, bPwm};

  // Two-flop synchronizers bring the asynchronous PWM levels into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pwm_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DEGLITCH_EN
  logic [2:0] prev_q, filt_q;

  // Filtered level follows the synchronized bit only once two consecutive
  // samples agree, so a lone one-cycle pulse never reaches the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      filt_q <= '0;
    end else begin
      prev_q <= sync2_q;
      filt_q <= (sync2_q & prev_q) | (filt_q & (sync2_q | prev_q));
    end
  end

  assign sample = filt_q;
`else
  assign sample = sync2_q;
`endif

  assign last_win = (win_q == {WINDOW_LOG2{1'b1}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; dropping en mid-window abandons the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? MEASURE : IDLE;
      MEASURE: begin
        if (!en)          state_d = IDLE;
        else if (last_win) state_d = REPORT;
        else              state_d = MEASURE;
      end
      REPORT:  state_d = en ? MEASURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls: counting only in an uninterrupted MEASURE cycle.
  always_comb begin
    busy       = (state_q == MEASURE);
    count_en   = (state_q == MEASURE) && en;
    load_pixel = (state_q == REPORT);
  end

  // Window position; cleared whenever not counting so every window starts at 0.
  always_ff @(posedge clk) begin
    if (rst || !count_en) win_q <= '0;
    else                  win_q <= win_q + 1'b1;
  end

  // One high-time counter per channel, one bit wider than the window so a
  // fully-high window (2^WINDOW_LOG2) is representable.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [WINDOW_LOG2:0] cnt_q;

    // Count cycles where this channel's sample is high.
    always_ff @(posedge clk) begin
      if (rst || !count_en) cnt_q <= '0;
      else if (sample[gi])  cnt_q <= cnt_q + 1'b1;
    end

    assign high_cnt[gi] = cnt_q;
  end

  logic [WINDOW_LOG2:0] r_shift, g_shift, b_shift;
  logic [4:0]           r_field, b_field;
  logic [5:0]           g_field;

  // Scale counts to field widths; a full window would overflow, so clamp it.
  always_comb begin
    r_shift = high_cnt[2] >> SHR;
    g_shift = high_cnt[1] >> SHG;
    b_shift = high_cnt[0] >> SHR;
    r_field = high_cnt[2][WINDOW_LOG2] ? 5'h1f  : r_shift[4:0];
    g_field = high_cnt[1][WINDOW_LOG2] ? 6'h3f  : g_shift[5:0];
    b_field = high_cnt[0][WINDOW_LOG2] ? 5'h1f  : b_shift[4:0];
  end

  // Pixel holds between windows; valid strobes with each new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_pixel;
      if (load_pixel) pixel_q <= {r_field, g_field, b_field};
    end
  end

  assign pixel      = pixel_q;
  assign pixelValid = valid_q;

endmodule

// File: doc/rgb_pwm_decoder.md
RGB_PWM_DECODER -- requirements
Module: rgb_pwm_decoder

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 Parameter WINDOW_LOG2, default 8, SHALL set the log2 of the measurement window length in clk cycles; legal range 6..16.
REQ-003 Ports SHALL be, one per line:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  en  in  1  decoder enable; low forces IDLE
  rPwm  in  1  red PWM input, asynchronous to clk
  gPwm  in  1  green PWM input, asynchronous to clk
  bPwm  in  1  blue PWM input, asynchronous to clk
  pixel  out  16  decoded RGB565 word {r[4:0], g[5:0], b[4:0]}, registered
  pixelValid  out  1  one-cycle pulse when pixel updates
  busy  out  1  high while in MEASURE

Function
REQ-004 Each PWM input SHALL pass through a 2-flop synchronizer before use; the synchronized bit is the channel sample.
REQ-005 The FSM SHALL have states IDLE, MEASURE, REPORT.
REQ-006 IDLE: counters cleared; if en=1, next state MEASURE, else stay IDLE.
REQ-007 MEASURE: lasts exactly 2^WINDOW_LOG2 cycles (window counter 0..2^WINDOW_LOG2-1); each cycle, each channel's high counter (WINDOW_LOG2+1 bits) increments when its sample is 1; after the last count, next state REPORT.
REQ-008 REPORT: lasts one cycle; sample in this cycle is discarded; pixel and pixelValid SHALL be registered at the end of this cycle; counters cleared; next state MEASURE if en=1, else IDLE.
REQ-009 Field mapping: r = hR >> (WINDOW_LOG2-5), g = hG >> (WINDOW_LOG2-6), b = hB >> (WINDOW_LOG2-5); a count equal to 2^WINDOW_LOG2 SHALL saturate to all ones (r=31, g=63, b=31).
REQ-010 pixelValid SHALL be high for exactly one cycle per completed window, the same cycle the new pixel first appears; pixel SHALL hold its value between updates.
REQ-011 en deasserted during MEASURE SHALL abort the window: next state IDLE, counters cleared, no pixelValid, pixel unchanged.
REQ-012 busy SHALL equal (state == MEASURE).
REQ-013 Windows are free-running and not phase-aligned to PWM edges; the result is the high-time fraction over the window.
REQ-014 Steady state: one pixelValid every 2^WINDOW_LOG2+1 cycles.

Reset
REQ-015 rst SHALL take priority over en and all FSM activity.
REQ-016 On rst: state IDLE, window and high counters 0, synchronizer flops 0, pixel 16'h0000, pixelValid 0, busy 0.
REQ-017 rst asserted mid-window SHALL discard the partial window; no pixelValid is produced for it.
REQ-018 First pixelValid after rst release with en=1 SHALL occur at the end of the REPORT cycle, i.e. 2^WINDOW_LOG2+2 cycles after the first non-reset edge.

Configuration
REQ-019 Macro PWM_DEGLITCH_EN SHALL, when defined, insert a per-channel filter after the synchronizer: the filtered sample changes only after the synchronized input holds a new level for 2 consecutive cycles; single-cycle pulses are suppressed; adds 1 cycle latency.
REQ-020 Without PWM_DEGLITCH_EN the synchronized bit SHALL be counted directly; no filter logic is present.

Verification (WINDOW_LOG2=8)
REQ-021 rPwm=1, gPwm=0, bPwm=0 constant, en=1 -> every pixelValid shows pixel=16'hF800 (red saturated).
REQ-022 All channels 50% duty, period 8 cycles -> pixel=16'h8410 (r=16, g=32, b=16); pixelValid spacing 257 cycles.
REQ-023 rst pulsed at window count 100 -> no pixelValid for that window, pixel=16'h0000, next pixelValid 258 cycles after rst release.
REQ-024 en dropped at window count 50 after a prior result 16'h8410 -> busy falls next cycle, no pixelValid, pixel stays 16'h8410.
REQ-025 rPwm 1-cycle high pulse every 4 cycles -> pixel r=8 without PWM_DEGLITCH_EN; r=0 with PWM_DEGLITCH_EN.
REQ-026 All inputs 0 -> pixel=16'h0000 with pixelValid still pulsing every 257 cycles.
